// File: rtl/rng_sop_pkg.sv
// Shared constants, capture-state encoding and word-select helper for the RNG side-output unpacker.
package rng_sop_pkg;

  localparam int SOP_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int IDX_W         = $clog2(WORDS_PER_BLK);

  typedef enum logic {
    CAP_IDLE,
    CAP_HOLD
  } cap_state_e;

  function automatic logic [WORD_W-1:0] blk_word(input logic [SOP_W-1:0] blk,
                                                 input logic [IDX_W-1:0] idx);
    return blk[WORD_W*idx +: WORD_W];
  endfunction

endpackage

// File: rtl/rng_sop_fifo.sv
// DEPTH x 128-bit register FIFO; push/pop/flush with level output.
// Latency: push visible at head/level on the next cycle; caller must not push when full or pop when empty.
// Backpressure: none internal, full/empty is derived by the caller from level_o.
module rng_sop_fifo
  import rng_sop_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [SOP_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [SOP_W-1:0] head_o,
  output logic [2:0]       level_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SOP_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]       level_q, level_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    level_d = level_q + {2'b00, push_i} - {2'b00, pop_i};
  end

  // Flush also zeroes storage so no stale random data survives a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      level_q <= level_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/rng_sop_unpacker.sv
// Captures 128-bit RNG side-output blocks into a FIFO and streams them as 32-bit words; optional repeat check under RNG_SOP_REPEAT_CHK_EN.
// Latency: block captured at edge N, sop_taken_1p and first out_valid in the cycle after N.
// Backpressure: out_ready low holds the word; a full FIFO stalls capture without losing sop_valid.
module rng_sop_unpacker
  import rng_sop_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              rng_clk,
  input  logic              rng_rst,
  input  logic              flush,
  input  logic              sop_valid,
  input  logic [SOP_W-1:0]  sop_data,
  output logic              sop_taken_1p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [2:0]        fifo_level,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic              rep_err_1p
);

  cap_state_e       cap_q, cap_d;
  logic             take_d, take_q;
  logic             push, pop, xfer, rep_hit;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SOP_W-1:0] head;
  logic [2:0]       level;

  rng_sop_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (rng_clk),
    .rst_i      (rng_rst),
    .flush_i    (flush),
    .push_i     (push),
    .push_dat_i (sop_data),
    .pop_i      (pop),
    .head_o     (head),
    .level_o    (level)
  );

  // HOLD swallows the cycle in which the producer still shows sop_valid after the take.
  always_comb begin
    cap_d  = cap_q;
    take_d = 1'b0;
    if (flush) begin
      cap_d = CAP_IDLE;
    end else begin
      case (cap_q)
        CAP_IDLE: begin
          if (sop_valid && (level < 3'(DEPTH))) begin
            take_d = 1'b1;
            cap_d  = CAP_HOLD;
          end
        end
        CAP_HOLD: cap_d = CAP_IDLE;
        default:  cap_d = CAP_IDLE;
      endcase
    end
  end

  assign push = take_d & ~rep_hit;

  assign out_valid = (level != 3'd0);
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (idx_q == IDX_W'(WORDS_PER_BLK - 1)) & ~flush;

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (flush) begin
      idx_d = '0;
    end else if (xfer) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (pop && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rng_clk) begin
    if (rng_rst) begin
      cap_q  <= CAP_IDLE;
      take_q <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      cap_q  <= cap_d;
      take_q <= take_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sop_taken_1p = take_q;
  assign out_data     = out_valid ? blk_word(head, idx_q) : '0;
  assign out_last     = out_valid & (idx_q == IDX_W'(WORDS_PER_BLK - 1));
  assign fifo_level   = level;
  assign blk_cnt      = cnt_q;

`ifdef RNG_SOP_REPEAT_CHK_EN
  logic [SOP_W-1:0] last_q;
  logic             last_vld_q;
  logic             rep_q;

  assign rep_hit = last_vld_q && (sop_data == last_q);

  // A repeated block is still acknowledged so the producer discards it.
  always_ff @(posedge rng_clk) begin
    if (rng_rst || flush) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      rep_q <= take_d & rep_hit;
      if (push) begin
        last_q     <= sop_data;
        last_vld_q <= 1'b1;
      end
    end
  end

  assign rep_err_1p = rep_q;
`else
  assign rep_hit    = 1'b0;
  assign rep_err_1p = 1'b0;
`endif

endmodule
